bfloat16_fma_bus_master: RTL and testbench
==========================================

// Module: bfloat16_fma_bus_master
// PURPOSE
//  Bus initiator that runs one complete bfloat16 FMA job on the memory-mapped FMA peripheral at BASE_ADDR.
//  Accepts a job (ctrl, op, A, B, C, rounding mode) on a valid/ready command port.
//  Issues 8 valid/ready bus transactions: 6 writes, then read of out and read of flags.
//  Returns the result on a valid/ready response port. Sits between a local sequencer and the peripheral bus.
// PARAMETERS
//  BASE_ADDR  32'h3000_0000  peripheral base; register offsets 0x00..0x1C are added to it
//  TIMEOUT    16             max cycles bus_valid may stay high without bus_ready before abort (>=2)
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  cmd_valid    in   1   job request valid
//  cmd_ready    out  1   high only in IDLE
//  cmd_ctrl     in   2   control: [0] -> wdata[0], [1] -> wdata[16]
//  cmd_op       in   4   op: [1:0] -> wdata[1:0], [3:2] -> wdata[17:16]
//  cmd_a        in   32  operand A (two packed bf16)
//  cmd_b        in   32  operand B
//  cmd_c        in   32  operand C
//  cmd_rm       in   6   rounding mode: [2:0] -> wdata[2:0], [5:3] -> wdata[18:16]
//  bus_valid    out  1   transaction request (registered)
//  bus_addr     out  32  BASE_ADDR + offset (registered)
//  bus_wstrb    out  4   byte enables; 0 = read (registered)
//  bus_wdata    out  32  write data (registered)
//  bus_ready    in   1   one-cycle completion pulse from peripheral
//  bus_rdata    in   32  read data, valid in the bus_ready cycle
//  rsp_valid    out  1   result valid; held until rsp_ready
//  rsp_ready    in   1   result accepted
//  rsp_out      out  32  captured out register (0x18)
//  rsp_flags    out  10  captured flags (0x1C, rdata[9:0])
//  rsp_timeout  out  1   job aborted on bus timeout; rsp_out and rsp_flags are 0
//  busy         out  1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE. bus_valid, bus_addr, bus_wstrb, bus_wdata all 0.
//   rsp_valid, rsp_out, rsp_flags and rsp_timeout are 0. cmd_ready is 1 in the first cycle after reset.
//  Reset mid-job: bus_valid is 0 in the next cycle. No response is produced.
//  FSM: IDLE -> BUS -> RESP -> IDLE.
//  Accept: cmd_valid & cmd_ready at edge E0 latches all cmd fields.
//   Transaction 0 is presented in cycle E0+1.
//  Transaction order (idx 0..7), offset / wstrb / wdata:
//   0 0x00 0101 {15'b0,ctrl[1],15'b0,ctrl[0]}
//   1 0x04 0101 {14'b0,op[3:2],14'b0,op[1:0]}
//   2 0x08 1111 A
//   3 0x0C 1111 B
//   4 0x10 1111 C
//   5 0x14 0101 {13'b0,rm[5:3],13'b0,rm[2:0]}
//   6 0x18 0000 read -> rsp_out
//   7 0x1C 0000 read -> rsp_flags
//  Bus handshake:
//   - addr, wstrb and wdata are held stable while bus_valid=1.
//   - A transaction completes on the edge where bus_valid & bus_ready.
//   - On that edge, the next transaction is loaded with bus_valid kept high. The peripheral ignores valid while its ready is high, so this is safe.
//   - Each transaction takes 2 cycles with a zero-wait peripheral.
//  Reads: bus_rdata is captured on the completing edge only.
//  Latency: with a zero-wait peripheral, rsp_valid rises in cycle E0+17; bus_valid=0 from that cycle on.
//  Timeout:
//   - A wait counter clears on every transaction load and increments each cycle bus_valid=1 & bus_ready=0.
//   - When the counter reaches TIMEOUT: bus_valid<=0, go to RESP with rsp_timeout=1, rsp_out=0, rsp_flags=0.
//   - bus_ready arriving after the abort is ignored.
//  bus_ready while bus_valid=0 (stray pulse) is ignored in every state.
//  RESP: rsp_valid=1, data stable until rsp_valid & rsp_ready, then IDLE next cycle.
//   cmd_ready=0 throughout RESP. A command is never accepted in the same cycle as the response handshake.
//  cmd_* inputs may change after acceptance without effect on the running job.
// TESTING
//  1 Zero-wait slave model. Job ctrl=2'b11, op=4'b0110, A=32'h3F80_4000, B=32'h4000_3F80, C=0, rm=6'o21.
//    -> 8 transactions at 0x3000_0000..0x3000_001C in order with the tabled wstrb/wdata.
//    -> rsp_valid at E0+17; rsp_out equals the model's 0x18 value.
//  2 Slave adds 3 wait cycles per transaction, TIMEOUT=16.
//    -> addr/wdata stable through waits, no abort, rsp_valid at E0+41, rsp_timeout=0.
//  3 Slave never answers the 0x0C write.
//    -> bus_valid drops after exactly TIMEOUT wait cycles; rsp_timeout=1, rsp_out=0, rsp_flags=0.
//    -> A later stray bus_ready causes no state change.
//  4 rsp_ready held 0 for 10 cycles with cmd_valid=1 throughout.
//    -> rsp_* stable, cmd_ready=0; next job accepted in the cycle after the rsp handshake.
//  5 reset asserted during transaction 3.
//    -> next cycle: bus_valid=0, rsp_valid=0, busy=0, cmd_ready=1.
//    -> A following job completes normally with all 8 transactions.

Source files
------------

// File: rtl/bfloat16_fma_bus_master_if.sv
// Signal bundle between the FMA job sequencer, the bus master and the FMA peripheral bus.
// The master modport is the bus master's view; slave is the environment's view.
interface bfloat16_fma_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_ctrl;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [31:0] cmd_c;
  logic [5:0]  cmd_rm;

  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_out;
  logic [9:0]  rsp_flags;
  logic        rsp_timeout;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_ctrl, cmd_op, cmd_a, cmd_b, cmd_c, cmd_rm,
    input  bus_ready, bus_rdata,
    input  rsp_ready,
    output cmd_ready,
    output bus_valid, bus_addr, bus_wstrb, bus_wdata,
    output rsp_valid, rsp_out, rsp_flags, rsp_timeout,
    output busy
  );

  modport slave (
    output cmd_valid, cmd_ctrl, cmd_op, cmd_a, cmd_b, cmd_c, cmd_rm,
    output bus_ready, bus_rdata,
    output rsp_ready,
    input  cmd_ready,
    input  bus_valid, bus_addr, bus_wstrb, bus_wdata,
    input  rsp_valid, rsp_out, rsp_flags, rsp_timeout,
    input  busy
  );
endinterface

// File: rtl/bfloat16_fma_bus_master.sv
// Runs one bfloat16 FMA job on the memory-mapped FMA peripheral: six register writes,
// then reads of the out and flags registers, with a per-transaction wait timeout.
module bfloat16_fma_bus_master #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input logic                       clk,
  input logic                       reset,
  bfloat16_fma_bus_master_if.master io
);

  localparam int unsigned      WaitW    = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam logic [WaitW-1:0] WaitOne  = WaitW'(1);
  localparam logic [2:0]       IdxOut   = 3'd6;
  localparam logic [2:0]       IdxFlags = 3'd7;

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [WaitW-1:0] wait_q, wait_d;

  logic [1:0]  ctrl_q, ctrl_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] c_q, c_d;
  logic [5:0]  rm_q, rm_d;

  logic        bus_valid_q, bus_valid_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic [31:0] rsp_out_q, rsp_out_d;
  logic [9:0]  rsp_flags_q, rsp_flags_d;
  logic        rsp_timeout_q, rsp_timeout_d;

  logic        load;
  logic [2:0]  load_idx;
  logic [3:0]  load_wstrb;
  logic [31:0] load_wdata;
  logic [1:0]  job_ctrl;
  logic        txn_done;
  logic        txn_stall;

  assign txn_done  = bus_valid_q & io.bus_ready;
  assign txn_stall = bus_valid_q & ~io.bus_ready;

  // Transaction 0 is loaded on the accepting edge, before ctrl_q holds the new job.
  assign job_ctrl = (state_q == StIdle) ? io.cmd_ctrl : ctrl_q;

  always_comb begin
    load_wstrb = 4'b0000;
    load_wdata = '0;
    unique case (load_idx)
      3'd0: begin
        load_wstrb = 4'b0101;
        load_wdata = {15'b0, job_ctrl[1], 15'b0, job_ctrl[0]};
      end
      3'd1: begin
        load_wstrb = 4'b0101;
        load_wdata = {14'b0, op_q[3:2], 14'b0, op_q[1:0]};
      end
      3'd2: begin
        load_wstrb = 4'b1111;
        load_wdata = a_q;
      end
      3'd3: begin
        load_wstrb = 4'b1111;
        load_wdata = b_q;
      end
      3'd4: begin
        load_wstrb = 4'b1111;
        load_wdata = c_q;
      end
      3'd5: begin
        load_wstrb = 4'b0101;
        load_wdata = {13'b0, rm_q[5:3], 13'b0, rm_q[2:0]};
      end
      default: begin
        load_wstrb = 4'b0000;
        load_wdata = '0;
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wait_d        = wait_q;
    ctrl_d        = ctrl_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    rm_d          = rm_q;
    bus_valid_d   = bus_valid_q;
    bus_addr_d    = bus_addr_q;
    bus_wstrb_d   = bus_wstrb_q;
    bus_wdata_d   = bus_wdata_q;
    rsp_out_d     = rsp_out_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_timeout_d = rsp_timeout_q;
    load          = 1'b0;
    load_idx      = idx_q + 3'd1;

    unique case (state_q)
      StIdle: begin
        if (io.cmd_valid) begin
          ctrl_d        = io.cmd_ctrl;
          op_d          = io.cmd_op;
          a_d           = io.cmd_a;
          b_d           = io.cmd_b;
          c_d           = io.cmd_c;
          rm_d          = io.cmd_rm;
          rsp_out_d     = '0;
          rsp_flags_d   = '0;
          rsp_timeout_d = 1'b0;
          load          = 1'b1;
          load_idx      = 3'd0;
          state_d       = StBus;
        end
      end
      StBus: begin
        if (txn_done) begin
          if (idx_q == IdxOut) begin
            rsp_out_d = io.bus_rdata;
          end
          if (idx_q == IdxFlags) begin
            rsp_flags_d = io.bus_rdata[9:0];
            bus_valid_d = 1'b0;
            state_d     = StResp;
          end else begin
            load = 1'b1;
          end
        end else if (txn_stall) begin
          if (wait_q == WaitLast) begin
            bus_valid_d   = 1'b0;
            rsp_out_d     = '0;
            rsp_flags_d   = '0;
            rsp_timeout_d = 1'b1;
            state_d       = StResp;
          end else begin
            wait_d = wait_q + WaitOne;
          end
        end
      end
      StResp: begin
        if (io.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Loading keeps bus_valid high so back-to-back transactions need no idle cycle.
    if (load) begin
      idx_d       = load_idx;
      wait_d      = '0;
      bus_valid_d = 1'b1;
      bus_addr_d  = BASE_ADDR + {27'b0, load_idx, 2'b00};
      bus_wstrb_d = load_wstrb;
      bus_wdata_d = load_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      wait_q        <= '0;
      ctrl_q        <= '0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      rm_q          <= '0;
      bus_valid_q   <= 1'b0;
      bus_addr_q    <= '0;
      bus_wstrb_q   <= '0;
      bus_wdata_q   <= '0;
      rsp_out_q     <= '0;
      rsp_flags_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wait_q        <= wait_d;
      ctrl_q        <= ctrl_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      rm_q          <= rm_d;
      bus_valid_q   <= bus_valid_d;
      bus_addr_q    <= bus_addr_d;
      bus_wstrb_q   <= bus_wstrb_d;
      bus_wdata_q   <= bus_wdata_d;
      rsp_out_q     <= rsp_out_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign io.cmd_ready   = (state_q == StIdle);
  assign io.busy        = (state_q != StIdle);
  assign io.rsp_valid   = (state_q == StResp);
  assign io.bus_valid   = bus_valid_q;
  assign io.bus_addr    = bus_addr_q;
  assign io.bus_wstrb   = bus_wstrb_q;
  assign io.bus_wdata   = bus_wdata_q;
  assign io.rsp_out     = rsp_out_q;
  assign io.rsp_flags   = rsp_flags_q;
  assign io.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_bfloat16_fma_bus_master.sv
// Bench for bfloat16_fma_bus_master: a registered peripheral model with configurable wait
// states logs every transaction; each scenario task compares against a job-level model.
module tb_bfloat16_fma_bus_master;
  localparam logic [31:0] Base    = 32'h3000_0000;
  localparam int          Timeout = 16;

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [5:0]  rm;
  } job_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  // Peripheral model configuration, written only by the main process.
  int          wait_cycles;
  logic        hang_en;
  logic [31:0] hang_addr;
  logic        stray;
  logic [31:0] model_out;
  logic [31:0] model_flags;

  // Peripheral model observations, written only by the peripheral process.
  logic [31:0] log_addr  [256];
  logic [3:0]  log_wstrb [256];
  logic [31:0] log_wdata [256];
  int          log_n;
  int          hang_cnt;
  int          unstable;

  bfloat16_fma_bus_master_if io ();

  bfloat16_fma_bus_master #(
    .BASE_ADDR(Base),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (io)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion within 200us");
    $fatal(1);
  end

  // Registered peripheral: raises bus_ready one cycle after seeing valid (plus wait_cycles).
  initial begin : periph
    int          cnt;
    logic        nxt;
    logic        hold;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic [3:0]  h_wstrb;
    logic [31:0] rd;
    cnt = 0; nxt = 1'b0; hold = 1'b0; h_addr = '0; h_wdata = '0; h_wstrb = '0; rd = '0;
    log_n = 0; hang_cnt = 0; unstable = 0;
    io.bus_ready = 1'b0;
    io.bus_rdata = '0;
    forever begin
      @(negedge clk);
      nxt = 1'b0;
      if (reset) begin
        cnt  = 0;
        hold = 1'b0;
      end else begin
        if (io.bus_valid === 1'b1) begin
          if (hold && (io.bus_addr !== h_addr || io.bus_wstrb !== h_wstrb ||
                       io.bus_wdata !== h_wdata)) unstable++;
          hold    = (io.bus_ready !== 1'b1);
          h_addr  = io.bus_addr;
          h_wstrb = io.bus_wstrb;
          h_wdata = io.bus_wdata;
        end else begin
          hold = 1'b0;
        end
        if (io.bus_ready === 1'b1) begin
          if (io.bus_valid === 1'b1 && log_n < 256) begin
            log_addr[log_n]  = io.bus_addr;
            log_wstrb[log_n] = io.bus_wstrb;
            log_wdata[log_n] = io.bus_wdata;
            log_n++;
          end
          cnt = 0;
        end else if (io.bus_valid === 1'b1) begin
          if (hang_en && io.bus_addr == hang_addr) begin
            hang_cnt++;
          end else if (cnt >= wait_cycles) begin
            nxt = 1'b1;
            cnt = 0;
            rd  = (io.bus_addr == Base + 32'h18) ? model_out : model_flags;
          end else begin
            cnt++;
          end
        end
      end
      @(posedge clk);
      #1;
      io.bus_ready = nxt | stray;
      io.bus_rdata = nxt ? rd : $urandom();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic job_t rand_job();
    job_t j;
    j.ctrl = 2'($urandom());
    j.op   = 4'($urandom());
    j.a    = $urandom();
    j.b    = $urandom();
    j.c    = $urandom();
    j.rm   = 6'($urandom());
    return j;
  endfunction

  // Register map of the FMA peripheral job sequence.
  function automatic logic [31:0] exp_wdata(input int i, input job_t j);
    case (i)
      0:       return {15'b0, j.ctrl[1], 15'b0, j.ctrl[0]};
      1:       return {14'b0, j.op[3:2], 14'b0, j.op[1:0]};
      2:       return j.a;
      3:       return j.b;
      4:       return j.c;
      5:       return {13'b0, j.rm[5:3], 13'b0, j.rm[2:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] exp_wstrb(input int i);
    if (i == 2 || i == 3 || i == 4) return 4'b1111;
    if (i <= 5) return 4'b0101;
    return 4'b0000;
  endfunction

  function automatic int txn_errors(input int base, input job_t j);
    int e;
    e = 0;
    for (int i = 0; i < 8; i++) begin
      if (log_addr[base+i] !== Base + 32'(4 * i)) e++;
      if (log_wstrb[base+i] !== exp_wstrb(i)) e++;
      if (i < 6 && log_wdata[base+i] !== exp_wdata(i, j)) e++;
    end
    return e;
  endfunction

  task automatic drive_cmd(input job_t j, input logic v);
    io.cmd_ctrl  = j.ctrl;
    io.cmd_op    = j.op;
    io.cmd_a     = j.a;
    io.cmd_b     = j.b;
    io.cmd_c     = j.c;
    io.cmd_rm    = j.rm;
    io.cmd_valid = v;
  endtask

  task automatic run_job(input job_t j, output int lat, output logic first_ok,
                         output logic [31:0] out, output logic [9:0] flags,
                         output logic to, output logic bv);
    drive_cmd(j, 1'b1);
    tick();
    first_ok = (io.bus_valid === 1'b1) && (io.bus_addr === Base);
    drive_cmd(rand_job(), 1'b0);
    lat = 0;
    while (io.rsp_valid !== 1'b1 && lat < 300) begin
      tick();
      lat++;
    end
    out   = io.rsp_out;
    flags = io.rsp_flags;
    to    = io.rsp_timeout;
    bv    = io.bus_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({io.bus_valid, io.bus_addr, io.bus_wstrb, io.bus_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_bus: got valid=%b addr=%h wstrb=%b wdata=%h, need all 0",
               io.bus_valid, io.bus_addr, io.bus_wstrb, io.bus_wdata);
    end
    checks++;
    if ({io.rsp_valid, io.rsp_out, io.rsp_flags, io.rsp_timeout} !== '0) begin
      failures++;
      $display("FAIL reset_rsp: got valid=%b out=%h flags=%h to=%b, need all 0",
               io.rsp_valid, io.rsp_out, io.rsp_flags, io.rsp_timeout);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({io.cmd_ready, io.busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_idle: got cmd_ready=%b busy=%b, need 1 0", io.cmd_ready, io.busy);
    end
  endtask

  task automatic test_zero_wait();
    job_t j;
    int lat, base;
    logic first_ok, to, bv;
    logic [31:0] out;
    logic [9:0] flags;
    j = '{ctrl: 2'b11, op: 4'b0110, a: 32'h3F80_4000, b: 32'h4000_3F80, c: 32'h0, rm: 6'o21};
    wait_cycles = 0;
    model_out   = $urandom();
    model_flags = $urandom();
    io.rsp_ready = 1'b1;
    base = log_n;
    run_job(j, lat, first_ok, out, flags, to, bv);
    checks++;
    if (first_ok !== 1'b1) begin
      failures++;
      $display("FAIL zw_first_txn: txn0 not presented in cycle after accept, need valid at %h", Base);
    end
    checks++;
    if (lat != 16) begin
      failures++;
      $display("FAIL zw_latency: rsp_valid %0d edges after accept, need 16", lat);
    end
    checks++;
    if (out !== model_out || flags !== model_flags[9:0] || to !== 1'b0 || bv !== 1'b0) begin
      failures++;
      $display("FAIL zw_rsp: got out=%h flags=%h to=%b bus_valid=%b, need %h %h 0 0",
               out, flags, to, bv, model_out, model_flags[9:0]);
    end
    tick();
    checks++;
    if ({io.rsp_valid, io.cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL zw_handshake: got rsp_valid=%b cmd_ready=%b, need 0 1",
               io.rsp_valid, io.cmd_ready);
    end
    checks++;
    if (log_n - base != 8 || txn_errors(base, j) != 0) begin
      failures++;
      $display("FAIL zw_txns: got %0d txns with %0d field errors, need 8 with 0",
               log_n - base, txn_errors(base, j));
    end
    checks++;
    if (log_wdata[base] !== 32'h0001_0001 || log_wdata[base+1] !== 32'h0001_0002 ||
        log_wdata[base+5] !== 32'h0002_0001) begin
      failures++;
      $display("FAIL zw_packing: got ctrl=%h op=%h rm=%h, need 00010001 00010002 00020001",
               log_wdata[base], log_wdata[base+1], log_wdata[base+5]);
    end
  endtask

  task automatic test_wait_states();
    job_t j;
    int lat, base, u0;
    logic first_ok, to, bv;
    logic [31:0] out;
    logic [9:0] flags;
    j = rand_job();
    wait_cycles = 3;
    model_out   = $urandom();
    model_flags = $urandom();
    io.rsp_ready = 1'b1;
    base = log_n;
    u0 = unstable;
    run_job(j, lat, first_ok, out, flags, to, bv);
    checks++;
    if (lat != 40 || to !== 1'b0) begin
      failures++;
      $display("FAIL ws_latency: got %0d edges timeout=%b, need 40 and 0", lat, to);
    end
    checks++;
    if (unstable != u0) begin
      failures++;
      $display("FAIL ws_stable: %0d cycles with changing addr/wstrb/wdata, need 0", unstable - u0);
    end
    checks++;
    if (out !== model_out || flags !== model_flags[9:0]) begin
      failures++;
      $display("FAIL ws_rsp: got out=%h flags=%h, need %h %h", out, flags, model_out,
               model_flags[9:0]);
    end
    tick();
    checks++;
    if (log_n - base != 8 || txn_errors(base, j) != 0) begin
      failures++;
      $display("FAIL ws_txns: got %0d txns with %0d field errors, need 8 with 0",
               log_n - base, txn_errors(base, j));
    end
  endtask

  task automatic test_back_to_back();
    job_t j;
    int lat, base, w;
    logic first_ok, to, bv;
    logic [31:0] out;
    logic [9:0] flags;
    io.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      j = rand_job();
      w = $urandom_range(0, 2);
      wait_cycles = w;
      model_out   = $urandom();
      model_flags = $urandom();
      base = log_n;
      run_job(j, lat, first_ok, out, flags, to, bv);
      checks++;
      if (lat != 8 * (w + 2) || out !== model_out || flags !== model_flags[9:0] || to !== 1'b0)
      begin
        failures++;
        $display("FAIL b2b_job%0d: got lat=%0d out=%h flags=%h to=%b, need %0d %h %h 0", k, lat,
                 out, flags, to, 8 * (w + 2), model_out, model_flags[9:0]);
      end
      tick();
      checks++;
      if (log_n - base != 8 || txn_errors(base, j) != 0) begin
        failures++;
        $display("FAIL b2b_txns%0d: got %0d txns with %0d field errors, need 8 with 0", k,
                 log_n - base, txn_errors(base, j));
      end
    end
  endtask

  task automatic test_timeout();
    job_t j;
    int n, base, h0, u0, ln;
    j = rand_job();
    wait_cycles = 0;
    hang_addr   = Base + 32'h0C;
    hang_en     = 1'b1;
    io.rsp_ready = 1'b0;
    base = log_n;
    h0 = hang_cnt;
    u0 = unstable;
    drive_cmd(j, 1'b1);
    tick();
    drive_cmd(rand_job(), 1'b0);
    n = 0;
    while (io.bus_valid === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (hang_cnt - h0 != Timeout || unstable != u0) begin
      failures++;
      $display("FAIL to_wait: valid held %0d unanswered cycles (%0d unstable), need %0d (0)",
               hang_cnt - h0, unstable - u0, Timeout);
    end
    checks++;
    if ({io.rsp_valid, io.rsp_timeout, io.rsp_out, io.rsp_flags} !== {2'b11, 42'h0}) begin
      failures++;
      $display("FAIL to_rsp: got valid=%b to=%b out=%h flags=%h, need 1 1 0 0",
               io.rsp_valid, io.rsp_timeout, io.rsp_out, io.rsp_flags);
    end
    checks++;
    if (log_n - base != 3) begin
      failures++;
      $display("FAIL to_txns: got %0d completed txns, need 3", log_n - base);
    end
    ln = log_n;
    stray = 1'b1;
    tick();
    tick();
    stray = 1'b0;
    tick();
    tick();
    checks++;
    if ({io.rsp_valid, io.rsp_timeout, io.busy, io.bus_valid, io.cmd_ready} !== 5'b11100 ||
        log_n != ln) begin
      failures++;
      $display("FAIL to_stray: got valid=%b to=%b busy=%b bus_valid=%b cmd_ready=%b, need 11100",
               io.rsp_valid, io.rsp_timeout, io.busy, io.bus_valid, io.cmd_ready);
    end
    hang_en = 1'b0;
    io.rsp_ready = 1'b1;
    tick();
    stray = 1'b1;
    tick();
    tick();
    stray = 1'b0;
    tick();
    checks++;
    if ({io.rsp_valid, io.busy, io.bus_valid, io.cmd_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL idle_stray: got rsp_valid=%b busy=%b bus_valid=%b cmd_ready=%b, need 0001",
               io.rsp_valid, io.busy, io.bus_valid, io.cmd_ready);
    end
  endtask

  task automatic test_rsp_backpressure();
    job_t j1, j2;
    int n, bad, base2;
    logic [31:0] out0, mo2;
    logic [9:0] flags0;
    j1 = rand_job();
    j2 = rand_job();
    wait_cycles = 0;
    model_out   = $urandom();
    model_flags = $urandom();
    io.rsp_ready = 1'b0;
    drive_cmd(j1, 1'b1);
    tick();
    drive_cmd(j2, 1'b1);
    n = 0;
    while (io.rsp_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    out0   = io.rsp_out;
    flags0 = io.rsp_flags;
    checks++;
    if (n != 16 || out0 !== model_out || flags0 !== model_flags[9:0]) begin
      failures++;
      $display("FAIL bp_job1: got lat=%0d out=%h flags=%h, need 16 %h %h", n, out0, flags0,
               model_out, model_flags[9:0]);
    end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (io.rsp_valid !== 1'b1 || io.rsp_out !== out0 || io.rsp_flags !== flags0 ||
          io.cmd_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold: %0d stalled cycles with changed rsp or cmd_ready=1, need 0", bad);
    end
    mo2 = $urandom();
    model_out = mo2;
    base2 = log_n;
    io.rsp_ready = 1'b1;
    tick();
    checks++;
    if ({io.rsp_valid, io.cmd_ready, io.bus_valid} !== 3'b010) begin
      failures++;
      $display("FAIL bp_release: got rsp_valid=%b cmd_ready=%b bus_valid=%b, need 0 1 0",
               io.rsp_valid, io.cmd_ready, io.bus_valid);
    end
    tick();
    checks++;
    if (io.bus_valid !== 1'b1 || io.bus_addr !== Base || io.bus_wdata !== exp_wdata(0, j2)) begin
      failures++;
      $display("FAIL bp_next_accept: got valid=%b addr=%h wdata=%h, need 1 %h %h",
               io.bus_valid, io.bus_addr, io.bus_wdata, Base, exp_wdata(0, j2));
    end
    drive_cmd(rand_job(), 1'b0);
    n = 0;
    while (io.rsp_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n != 16 || io.rsp_out !== mo2 || log_n - base2 != 8 || txn_errors(base2, j2) != 0) begin
      failures++;
      $display("FAIL bp_job2: got lat=%0d out=%h txns=%0d errs=%0d, need 16 %h 8 0", n,
               io.rsp_out, log_n - base2, txn_errors(base2, j2), mo2);
    end
    tick();
  endtask

  task automatic test_reset_mid_job();
    job_t j;
    int n, lat, base;
    logic first_ok, to, bv;
    logic [31:0] out;
    logic [9:0] flags;
    j = rand_job();
    wait_cycles = 1;
    io.rsp_ready = 1'b1;
    drive_cmd(j, 1'b1);
    tick();
    drive_cmd(rand_job(), 1'b0);
    n = 0;
    while (!(io.bus_valid === 1'b1 && io.bus_addr === Base + 32'h0C) && n < 100) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({io.bus_valid, io.rsp_valid, io.busy, io.cmd_ready} !== 4'b0001 || n >= 100) begin
      failures++;
      $display("FAIL mid_reset: got bus_valid=%b rsp_valid=%b busy=%b cmd_ready=%b, need 0001",
               io.bus_valid, io.rsp_valid, io.busy, io.cmd_ready);
    end
    j = rand_job();
    wait_cycles = 0;
    model_out   = $urandom();
    model_flags = $urandom();
    base = log_n;
    run_job(j, lat, first_ok, out, flags, to, bv);
    checks++;
    if (lat != 16 || out !== model_out || flags !== model_flags[9:0] || to !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_job: got lat=%0d out=%h flags=%h to=%b, need 16 %h %h 0", lat,
               out, flags, to, model_out, model_flags[9:0]);
    end
    tick();
    checks++;
    if (log_n - base != 8 || txn_errors(base, j) != 0) begin
      failures++;
      $display("FAIL post_reset_txns: got %0d txns with %0d field errors, need 8 with 0",
               log_n - base, txn_errors(base, j));
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    wait_cycles = 0;
    hang_en     = 1'b0;
    hang_addr   = '0;
    stray       = 1'b0;
    model_out   = '0;
    model_flags = '0;
    reset       = 1'b1;
    io.rsp_ready = 1'b0;
    drive_cmd('0, 1'b0);

    test_reset();
    test_zero_wait();
    test_wait_states();
    test_back_to_back();
    test_timeout();
    test_rsp_backpressure();
    test_reset_mid_job();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
